// File: rtl/sfx_player.sv
// Single-voice sound-effect sequencer: paces a sample ROM at the playback
// rate on the system clock and emits one scaled signed sample per tick.
module sfx_player #(
   parameter int TICK_DIV  = 12288,
   parameter int ADDR_W    = 17,
   parameter int LAST_ADDR = 6458
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [1:0]        vol,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [15:0]       sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_READ,
      S_ADVANCE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_sample;
   logic                r_valid;
   logic                r_done;

   logic                w_tick;
   logic                w_last;
   logic signed [15:0]  w_scaled;

   assign w_tick   = (r_cnt == CNT_W'(TICK_DIV - 1));
   assign w_last   = (r_addr == ADDR_W'(LAST_ADDR));
   assign w_scaled = $signed({rom_data, 8'h00}) >>> vol;

   // Free-running pacing counter; commands never restart it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_sample <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         if (stop && r_state != S_IDLE) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_sample <= '0;
         end else if (start && r_state != S_IDLE) begin
            r_state <= S_WAIT_TICK;
            r_addr  <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state <= S_WAIT_TICK;
                     r_addr  <= '0;
                  end
               end
               S_WAIT_TICK: begin
                  if (w_tick) begin
                     r_state <= S_READ;
                  end
               end
               S_READ: begin
                  r_sample <= w_scaled;
                  r_valid  <= 1'b1;
                  r_state  <= S_ADVANCE;
               end
               S_ADVANCE: begin
                  if (!w_last) begin
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_state <= S_WAIT_TICK;
                  end else if (loop_en) begin
                     r_addr  <= '0;
                     r_state <= S_WAIT_TICK;
                  end else begin
                     r_addr   <= '0;
                     r_sample <= '0;
                     r_done   <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign rom_addr     = r_addr;
   assign sample       = r_sample;
   assign sample_valid = r_valid;
   assign done         = r_done;
   assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player with a 4-entry ROM model,
// TICK_DIV=8 and LAST_ADDR=3.
module tb_sfx_player;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [1:0]  vol = 2'd0;
   logic [3:0]  rom_addr;
   logic [7:0]  rom_data = 8'h00;
   logic [15:0] sample;
   logic        sample_valid;
   logic        busy;
   logic        done;

   sfx_player #(
      .TICK_DIV (8),
      .ADDR_W   (4),
      .LAST_ADDR(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .vol         (vol),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .sample      (sample),
      .sample_valid(sample_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   logic [7:0]  rom [4]   = '{8'h7F, 8'h80, 8'h01, 8'hFF};
   logic [15:0] exp_v0 [4] = '{16'h7F00, 16'h8000, 16'h0100, 16'hFF00};
   logic [15:0] exp_v2 [4] = '{16'h1FC0, 16'hE000, 16'h0040, 16'hFFC0};

   always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   typedef struct {
      bit          is_done;
      logic [15:0] val;
      int          cyc;
   } ev_t;

   ev_t q[$];
   ev_t ev;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit d, input logic [15:0] v, input int c);
      ev_t e;
      e.is_done = d;
      e.val     = v;
      e.cyc     = c;
      q.push_back(e);
   endtask

   task automatic push_pass(input bit v2, input bit with_done, input int c0);
      for (int i = 0; i < 4; i++)
         push_ev(1'b0, v2 ? exp_v2[i] : exp_v0[i], c0 < 0 ? -1 : c0 + 8 * i);
      if (with_done)
         push_ev(1'b1, 16'h0, c0 < 0 ? -1 : c0 + 25);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic align(input int k);
      int n = 0;
      while (cyc % 8 != k && n < 16) begin
         step();
         n++;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", q.size(), 0);
      q.delete();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (sample_valid && done)
            check("valid_and_done", 1, 0);
         if (sample_valid || done) begin
            if (q.size() == 0) begin
               check("unexpected_event", {sample_valid, done}, 0);
            end else begin
               ev = q.pop_front();
               check("event_kind", done, ev.is_done);
               if (ev.is_done) begin
                  check("done_sample", sample, 0);
                  check("done_busy", busy, 0);
               end else begin
                  check("sample", sample, ev.val);
               end
               if (ev.cyc >= 0)
                  check("event_cycle", cyc, ev.cyc);
            end
         end
      end
   end

   initial begin
      int c;
      repeat (3) step();
      rst = 1'b0;
      check("rst_addr", rom_addr, 0);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // basic pass with exact cycle timing
      step();
      step();
      check("busy_pre_start", busy, 0);
      push_pass(1'b0, 1'b1, 9);
      pulse_start();
      check("busy_rise", busy, 1);
      drain(100);

      // attenuated pass
      vol = 2'd2;
      push_pass(1'b1, 1'b1, -1);
      pulse_start();
      drain(100);
      vol = 2'd0;

      // looping: two wrapped passes, then a final finishing pass
      loop_en = 1'b1;
      push_pass(1'b0, 1'b0, -1);
      push_pass(1'b0, 1'b0, -1);
      pulse_start();
      drain(200);
      loop_en = 1'b0;
      push_pass(1'b0, 1'b1, -1);
      drain(100);

      // stop in WAIT_TICK after the second sample
      push_ev(1'b0, exp_v0[0], -1);
      push_ev(1'b0, exp_v0[1], -1);
      pulse_start();
      drain(100);
      check("pre_stop_addr", rom_addr, 2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_sample", sample, 0);
      check("stop_addr", rom_addr, 0);
      repeat (24) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_idle_busy", busy, 0);

      // start on the tick cycle misses that tick
      align(7);
      c = cyc;
      push_pass(1'b0, 1'b1, c + 10);
      pulse_start();
      drain(100);

      // retrigger at addr 2
      push_ev(1'b0, exp_v0[0], -1);
      push_ev(1'b0, exp_v0[1], -1);
      pulse_start();
      drain(100);
      check("retrig_addr", rom_addr, 2);
      push_pass(1'b0, 1'b1, -1);
      pulse_start();
      drain(100);

      // simultaneous start/stop while busy
      push_ev(1'b0, exp_v0[0], -1);
      align(2);
      pulse_start();
      drain(100);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("both_busy", busy, 0);
      check("both_addr", rom_addr, 0);
      check("both_sample", sample, 0);

      // reset asserted during READ
      align(2);
      pulse_start();
      align(0);
      check("read_busy", busy, 1);
      rst = 1'b1;
      step();
      check("midrst_addr", rom_addr, 0);
      check("midrst_sample", sample, 0);
      check("midrst_valid", sample_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      rst = 1'b0;
      repeat (20) step();
      check("final_queue", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sfx_player.md
# sfx_player

Single-voice sound-effect sequencer. It paces a synchronous 8-bit sample ROM at the playback rate, handles start/stop/loop commands and volume, and presents one signed 16-bit sample per playback tick. It sits directly upstream of `speaker_control` and drives both of its channel inputs. It replaces the ad-hoc divided-clock playback logic: everything runs on the system clock, using clock-enables.

## Interface
Parameters:
- `TICK_DIV`, default 12288: system-clock cycles per playback tick (100 MHz / 12288 ≈ 8138 Hz); minimum 4.
- `ADDR_W`, default 17: ROM address width.
- `LAST_ADDR`, default 6458: address of the final sample of the clip.

Ports:
- `clk`, in, 1: system clock (100 MHz). Sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; begin or retrigger playback from address 0.
- `stop`, in, 1: one-cycle pulse; abort playback.
- `loop_en`, in, 1: when 1, wrap to address 0 after `LAST_ADDR` instead of finishing.
- `vol`, in, 2: attenuation; arithmetic right shift of the sample by `vol` bits.
- `rom_addr`, out, ADDR_W: ROM address; always equals the internal address register.
- `rom_data`, in, 8: signed ROM output, valid one cycle after `rom_addr` is sampled.
- `sample`, out, 16: signed audio sample for `speaker_control`.
- `sample_valid`, out, 1: one-cycle strobe marking a newly loaded `sample`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a non-looping clip completes.

## Operation
- Tick counter: free-running 0..TICK_DIV-1, wraps to 0. `tick` = (count == TICK_DIV-1). The counter runs in all states and is never restarted by `start`.
- States: IDLE, WAIT_TICK, READ, ADVANCE.
- IDLE: on `start`, set addr to 0 and go to WAIT_TICK.
- WAIT_TICK: on `tick`, go to READ.
- READ (one cycle): `rom_data` is valid for addr. At the end of the cycle:
  - `sample` <= ({rom_data, 8'h00}) >>> vol, arithmetic and sign-preserving.
  - `sample_valid` <= 1.
  - Go to ADVANCE.
- ADVANCE (one cycle):
  - If addr != LAST_ADDR: addr <= addr+1, go to WAIT_TICK.
  - If addr == LAST_ADDR and `loop_en`=1: addr <= 0, go to WAIT_TICK.
  - If addr == LAST_ADDR and `loop_en`=0: addr <= 0, `sample` <= 0, `done` <= 1, go to IDLE.
- `loop_en` is sampled only in ADVANCE at LAST_ADDR.
- `vol` is sampled only in READ; `sample` is not rescaled between ticks.
- Command priority, evaluated every cycle, highest first:
  1. `rst`.
  2. `stop` in a non-IDLE state: go to IDLE, addr <= 0, `sample` <= 0, no `done` pulse, and no `sample_valid` in the following cycle.
  3. `start` in a non-IDLE state: addr <= 0, go to WAIT_TICK (retrigger). No `done` pulse.
  4. Normal transitions.
- `stop` in IDLE is ignored. `start` and `stop` asserted in the same cycle: `stop` wins.
- Each clip address is emitted exactly once per pass: addresses 0..LAST_ADDR, LAST_ADDR+1 samples per pass.

## Timing
- Reset values: state IDLE, tick count 0, addr 0, `rom_addr` 0, `sample` 0, `sample_valid` 0, `busy` 0, `done` 0.
- Let T be a cycle with `tick`=1 in WAIT_TICK:
  - T+1: READ.
  - T+2: ADVANCE; `sample`/`sample_valid` updated (`sample_valid` high for this cycle only); `rom_addr` still the old address.
  - T+3: `rom_addr` shows the next address; state is WAIT_TICK, or IDLE with `done`=1.
- `busy` rises in the cycle after `start` and falls in the same cycle `done` rises, or in the cycle after `stop`.
- Steady-state output rate: exactly one `sample_valid` per TICK_DIV cycles.
- First sample after `start`: on the next tick.
  - If `start` arrives in the cycle where count == TICK_DIV-1, that tick is missed and the first sample waits a full period.
- `done` and `sample_valid` are never high in the same cycle.

## Test plan
All scenarios use TICK_DIV=8 and LAST_ADDR=3, with a ROM model holding {0x7F, 0x80, 0x01, 0xFF}.
- Reset, then `start` at cycle 2 -> `sample_valid` at cycles 9, 17, 25, 33 with `sample` 0x7F00, 0x8000, 0x0100, 0xFF00; `done` at cycle 34 with `sample`=0, `busy`=0.
- Same run with `vol`=2 -> `sample` 0x1FC0, 0xE000, 0x0040, 0xFFC0.
- `loop_en`=1 -> sample sequence 0x7F00, 0x8000, 0x0100, 0xFF00, 0x7F00, ... with no `done` pulse. Drop `loop_en` to 0 -> `done` after the next 0xFF00.
- `stop` pulse while in WAIT_TICK after the second sample -> IDLE next cycle, `sample`=0, `rom_addr`=0, no further `sample_valid`, no `done`.
- `start` retrigger while addr=2 -> next sample is 0x7F00 (address 0), and the full 4-sample pass completes with `done`.
- `start` and `stop` in the same cycle while busy -> IDLE. Then `rst` asserted mid-READ -> all outputs return to their reset values on the next cycle.
